fft_frame_scheduler: RTL and testbench

- Sits in front of the 32-point radix-2 SDF FFT core and sequences it.
- Arbitrates, round-robin and per whole frame, between two 12-bit complex sample sources.
- Drives the core with exactly 32 contiguous in_valid cycles per frame, which the SDF pipeline requires.
- Tags each 32-sample output frame from the core with its source channel, output index and last marker.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_frame_scheduler_if.sv | 13 +
 rtl/fft_tag_fifo.sv | 57 +++++
 rtl/fft_frame_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and sample payload type for the FFT frame scheduler.
package fft_pkg;

    localparam int unsigned FFT_N            = 32;
    localparam int unsigned FFT_LOG2N        = 5;
    localparam int unsigned IN_W             = 12;
    localparam int unsigned OUT_W            = 16;
    localparam int unsigned MAX_INFLIGHT_DEF = 2;
    localparam int unsigned MIN_GAP_DEF      = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        GAP  = 2'd2
    } fft_state_e;

    typedef struct packed {
        logic signed [IN_W-1:0] re;
        logic signed [IN_W-1:0] im;
    } fft_in_sample_t;

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Sample source handshake: the source is master, the scheduler is slave.
interface fft_frame_scheduler_if;
    import fft_pkg::*;

    logic                   valid;
    logic                   ready;
    logic signed [IN_W-1:0] din_r;
    logic signed [IN_W-1:0] din_i;

    modport master (output valid, output din_r, output din_i, input ready);
    modport slave  (input valid, input din_r, input din_i, output ready);

endinterface

// File: rtl/fft_tag_fifo.sv
// Channel-tag FIFO: one entry per frame issued to the core, popped when its outputs finish.
// A pop in the same cycle as a push reads the old head, so a full FIFO still accepts the push.
module fft_tag_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic head_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Round-robin whole-frame arbiter in front of a 32-point SDF FFT core, plus output tagging.
module fft_frame_scheduler
    import fft_pkg::*;
#(
    parameter  int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter  int unsigned MIN_GAP      = MIN_GAP_DEF,
    localparam int unsigned INFL_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    fft_frame_scheduler_if.slave        s0,
    fft_frame_scheduler_if.slave        s1,
    output logic                        fft_in_valid,
    output logic signed [IN_W-1:0]      fft_din_r,
    output logic signed [IN_W-1:0]      fft_din_i,
    input  logic                        fft_out_valid,
    input  logic signed [OUT_W-1:0]     fft_dout_r,
    input  logic signed [OUT_W-1:0]     fft_dout_i,
    output logic                        m_valid,
    output logic signed [OUT_W-1:0]     m_dout_r,
    output logic signed [OUT_W-1:0]     m_dout_i,
    output logic                        m_chan,
    output logic [FFT_LOG2N-1:0]        m_idx,
    output logic                        m_last,
    output logic                        busy,
    output logic [INFL_W-1:0]           inflight,
    output logic [1:0]                  underrun,
    output logic                        orphan_err
);

    localparam logic [FFT_LOG2N-1:0] LAST_IDX = FFT_LOG2N'(FFT_N - 1);
    localparam int unsigned          GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    fft_state_e             state_q;
    logic                   last_grant_q;
    logic                   chan_q;
    logic [FFT_LOG2N-1:0]   samp_cnt_q;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic [INFL_W-1:0]      inflight_q;
    logic [INFL_W-1:0]      inflight_d;
    logic [1:0]             underrun_q;
    logic                   orphan_q;
    logic                   in_valid_q;
    fft_in_sample_t         din_q;
    logic [FFT_LOG2N-1:0]   out_cnt_q;
    logic                   m_valid_q;
    logic signed [OUT_W-1:0] m_dout_r_q;
    logic signed [OUT_W-1:0] m_dout_i_q;
    logic                   m_chan_q;
    logic [FFT_LOG2N-1:0]   m_idx_q;
    logic                   m_last_q;

    logic                   room_c;
    logic                   elig0_c;
    logic                   elig1_c;
    logic                   grant_c;
    logic                   grant_ch_c;
    logic                   slot_c;
    logic                   slot_ch_c;
    logic                   sel_valid_c;
    fft_in_sample_t         sel_c;
    logic                   out_pop_c;
    logic                   fifo_head_c;
    logic                   fifo_empty_c;

    // Grant decision and sample-slot selection; sample 0 is taken in the grant cycle.
    always_comb begin
        room_c      = (inflight_q < INFL_W'(MAX_INFLIGHT));
        elig0_c     = !rst && (state_q == IDLE) && room_c && s0.valid;
        elig1_c     = !rst && (state_q == IDLE) && room_c && s1.valid;
        grant_c     = elig0_c || elig1_c;
        grant_ch_c  = (elig0_c && elig1_c) ? !last_grant_q : elig1_c;
        slot_c      = !rst && (grant_c || (state_q == FEED));
        slot_ch_c   = (state_q == FEED) ? chan_q : grant_ch_c;
        sel_valid_c = slot_ch_c ? s1.valid : s0.valid;
        sel_c.re    = slot_ch_c ? s1.din_r : s0.din_r;
        sel_c.im    = slot_ch_c ? s1.din_i : s0.din_i;
    end

    assign s0.ready = slot_c && !slot_ch_c;
    assign s1.ready = slot_c && slot_ch_c;

    // A frame's tag retires on the core output that carries index 31.
    assign out_pop_c = fft_out_valid && (out_cnt_q == LAST_IDX) && !fifo_empty_c;

    // Outstanding-frame count; a same-cycle grant and retire cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (grant_c && !out_pop_c) begin
            inflight_d = inflight_q + INFL_W'(1);
        end else if (out_pop_c && !grant_c) begin
            inflight_d = inflight_q - INFL_W'(1);
        end
    end

    fft_tag_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (grant_c),
        .din_i   (grant_ch_c),
        .pop_i   (out_pop_c),
        .head_o  (fifo_head_c),
        .empty_o (fifo_empty_c)
    );

    // Input-side FSM, core input register and underrun flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            chan_q       <= 1'b0;
            samp_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            inflight_q   <= '0;
            underrun_q   <= '0;
            in_valid_q   <= 1'b0;
            din_q        <= '0;
        end else begin
            inflight_q <= inflight_d;
            in_valid_q <= slot_c;
            if (slot_c && sel_valid_c) begin
                din_q <= sel_c;
            end else begin
                din_q <= '0;
            end
            if (slot_c && !sel_valid_c) begin
                underrun_q[slot_ch_c] <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        state_q      <= FEED;
                        chan_q       <= grant_ch_c;
                        last_grant_q <= grant_ch_c;
                        samp_cnt_q   <= FFT_LOG2N'(1);
                    end
                end
                FEED: begin
                    samp_cnt_q <= samp_cnt_q + FFT_LOG2N'(1);
                    if (samp_cnt_q == LAST_IDX) begin
                        samp_cnt_q <= '0;
                        gap_cnt_q  <= '0;
                        state_q    <= (MIN_GAP > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_W'(MIN_GAP - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output tagging: registered copy of core output with channel, index and last marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_q  <= '0;
            m_valid_q  <= 1'b0;
            m_dout_r_q <= '0;
            m_dout_i_q <= '0;
            m_chan_q   <= 1'b0;
            m_idx_q    <= '0;
            m_last_q   <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            m_valid_q <= fft_out_valid;
            if (fft_out_valid) begin
                m_dout_r_q <= fft_dout_r;
                m_dout_i_q <= fft_dout_i;
                m_chan_q   <= fifo_empty_c ? 1'b0 : fifo_head_c;
                m_idx_q    <= out_cnt_q;
                m_last_q   <= (out_cnt_q == LAST_IDX);
                out_cnt_q  <= out_cnt_q + FFT_LOG2N'(1);
                if (fifo_empty_c) begin
                    orphan_q <= 1'b1;
                end
            end
        end
    end

    assign fft_in_valid = in_valid_q;
    assign fft_din_r    = din_q.re;
    assign fft_din_i    = din_q.im;
    assign m_valid      = m_valid_q;
    assign m_dout_r     = m_dout_r_q;
    assign m_dout_i     = m_dout_i_q;
    assign m_chan       = m_chan_q;
    assign m_idx        = m_idx_q;
    assign m_last       = m_last_q;
    assign busy         = (state_q != IDLE) || (inflight_q != '0);
    assign inflight     = inflight_q;
    assign underrun     = underrun_q;
    assign orphan_err   = orphan_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for the FFT frame scheduler with hand-computed expectations.
module tb_fft_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        fft_in_valid;
    logic [11:0] fft_din_r;
    logic [11:0] fft_din_i;
    logic        fft_out_valid;
    logic [15:0] fft_dout_r;
    logic [15:0] fft_dout_i;
    logic        m_valid;
    logic [15:0] m_dout_r;
    logic [15:0] m_dout_i;
    logic        m_chan;
    logic [4:0]  m_idx;
    logic        m_last;
    logic        busy;
    logic [1:0]  inflight;
    logic [1:0]  underrun;
    logic        orphan_err;

    int n_checks = 0;
    int n_errors = 0;

    fft_frame_scheduler_if s0_if ();
    fft_frame_scheduler_if s1_if ();

    fft_frame_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .s0            (s0_if),
        .s1            (s1_if),
        .fft_in_valid  (fft_in_valid),
        .fft_din_r     (fft_din_r),
        .fft_din_i     (fft_din_i),
        .fft_out_valid (fft_out_valid),
        .fft_dout_r    (fft_dout_r),
        .fft_dout_i    (fft_dout_i),
        .m_valid       (m_valid),
        .m_dout_r      (m_dout_r),
        .m_dout_i      (m_dout_i),
        .m_chan        (m_chan),
        .m_idx         (m_idx),
        .m_last        (m_last),
        .busy          (busy),
        .inflight      (inflight),
        .underrun      (underrun),
        .orphan_err    (orphan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_if.valid   = 1'b0;
        s0_if.din_r   = '0;
        s0_if.din_i   = '0;
        s1_if.valid   = 1'b0;
        s1_if.din_r   = '0;
        s1_if.din_i   = '0;
        fft_out_valid = 1'b0;
        fft_dout_r    = '0;
        fft_dout_i    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    // One source-0 frame x[k]=k+j(k+100); valid dropped for samples lo..hi.
    task automatic feed0(input int lo, input int hi);
        logic dropped;
        for (int k = 0; k <= 33; k++) begin
            cyc();
            if (k < 32) begin
                s0_if.valid = !(k >= lo && k <= hi);
                s0_if.din_r = 12'(k);
                s0_if.din_i = 12'(k + 100);
            end else begin
                s0_if.valid = 1'b0;
            end
            #1;
            chk("s0_ready", 32'(s0_if.ready), 32'(k < 32));
            chk("s1_ready", 32'(s1_if.ready), 32'(0));
            if (k >= 1) begin
                chk("in_valid", 32'(fft_in_valid), 32'(k <= 32));
            end
            if (k >= 1 && k <= 32) begin
                dropped = (k - 1 >= lo) && (k - 1 <= hi);
                chk("din_r", 32'(fft_din_r), dropped ? 32'(0) : 32'(k - 1));
                chk("din_i", 32'(fft_din_i), dropped ? 32'(0) : 32'(k + 99));
            end
        end
    endtask

    // Core model returning 32 outputs; checks the tagged copy one cycle later.
    task automatic core_out(input logic exp_chan);
        logic [15:0] v;
        for (int k = 0; k <= 32; k++) begin
            cyc();
            if (k < 32) begin
                fft_out_valid = 1'b1;
                fft_dout_r    = 16'(k * 37 - 500);
                fft_dout_i    = 16'(k);
            end else begin
                fft_out_valid = 1'b0;
            end
            #1;
            if (k > 0) begin
                v = 16'((k - 1) * 37 - 500);
                chk("m_valid", 32'(m_valid), 32'(1));
                chk("m_idx", 32'(m_idx), 32'(k - 1));
                chk("m_last", 32'(m_last), 32'(k == 32));
                chk("m_chan", 32'(m_chan), 32'(exp_chan));
                chk("m_dout_r", 32'(m_dout_r), 32'(v));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic exp_r0;
        logic exp_r1;
        logic exp_iv;

        // Reset state, observed while rst is still high.
        rst = 1'b1;
        idle_inputs();
        repeat (2) cyc();
        chk("rst_in_valid", 32'(fft_in_valid), 32'(0));
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_inflight", 32'(inflight), 32'(0));
        chk("rst_underrun", 32'(underrun), 32'(0));
        chk("rst_orphan", 32'(orphan_err), 32'(0));
        chk("rst_s0_ready", 32'(s0_if.ready), 32'(0));
        rst = 1'b0;

        // Single source-0 frame, then its outputs.
        feed0(99, 99);
        chk("t1_inflight", 32'(inflight), 32'(1));
        chk("t1_busy", 32'(busy), 32'(1));
        chk("t1_underrun", 32'(underrun), 32'(0));
        core_out(1'b0);
        chk("t1_inflight_done", 32'(inflight), 32'(0));
        chk("t1_busy_done", 32'(busy), 32'(0));

        // Samples 10..12 missing: zero substituted, frame never stalls.
        feed0(10, 12);
        chk("ur_flag", 32'(underrun), 32'(2'b01));
        core_out(1'b0);
        rst = 1'b1;
        cyc();
        chk("ur_cleared", 32'(underrun), 32'(0));
        rst = 1'b0;

        // Both sources valid: ch0 at 0..31, gap, ch1 at 33..64, gap, then blocked at 2 in flight.
        do_reset();
        for (int c = 0; c <= 75; c++) begin
            cyc();
            if (c == 0) begin
                s0_if.valid = 1'b1;
                s0_if.din_r = 12'd5;
                s1_if.valid = 1'b1;
                s1_if.din_r = 12'd7;
            end
            #1;
            exp_r0 = (c <= 31);
            exp_r1 = (c >= 33 && c <= 64);
            chk("rr_s0_ready", 32'(s0_if.ready), 32'(exp_r0));
            chk("rr_s1_ready", 32'(s1_if.ready), 32'(exp_r1));
            if (c >= 1) begin
                exp_iv = (c <= 32) || (c >= 34 && c <= 65);
                chk("rr_in_valid", 32'(fft_in_valid), 32'(exp_iv));
                if (exp_iv) begin
                    chk("rr_din_r", 32'(fft_din_r), (c <= 32) ? 32'(5) : 32'(7));
                end
            end
        end
        chk("rr_inflight_full", 32'(inflight), 32'(2));
        chk("rr_busy_full", 32'(busy), 32'(1));
        s1_if.valid = 1'b0;
        core_out(1'b0);
        chk("rr_regrant_s0", 32'(s0_if.ready), 32'(1));
        chk("rr_regrant_s1", 32'(s1_if.ready), 32'(0));
        chk("rr_inflight_pop", 32'(inflight), 32'(1));
        repeat (32) cyc();
        s0_if.valid = 1'b0;
        core_out(1'b1);
        core_out(1'b0);
        chk("rr_inflight_done", 32'(inflight), 32'(0));
        chk("rr_busy_done", 32'(busy), 32'(0));
        chk("rr_underrun", 32'(underrun), 32'(0));

        // Core output with no frame issued.
        do_reset();
        cyc();
        fft_out_valid = 1'b1;
        fft_dout_r    = 16'h1234;
        cyc();
        fft_out_valid = 1'b0;
        #1;
        chk("orph_flag", 32'(orphan_err), 32'(1));
        chk("orph_m_valid", 32'(m_valid), 32'(1));
        chk("orph_m_chan", 32'(m_chan), 32'(0));
        chk("orph_m_idx", 32'(m_idx), 32'(0));
        chk("orph_m_dout", 32'(m_dout_r), 32'h1234);
        chk("orph_inflight", 32'(inflight), 32'(0));
        cyc();
        chk("orph_m_valid_off", 32'(m_valid), 32'(0));

        // Reset asserted in the slot of sample 17.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            cyc();
            s0_if.valid = 1'b1;
            s0_if.din_r = 12'(k);
            #1;
            chk("mid_s0_ready", 32'(s0_if.ready), 32'(1));
        end
        cyc();
        rst         = 1'b1;
        s0_if.valid = 1'b0;
        cyc();
        chk("mid_in_valid", 32'(fft_in_valid), 32'(0));
        chk("mid_din_r", 32'(fft_din_r), 32'(0));
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_inflight", 32'(inflight), 32'(0));
        chk("mid_s0_ready", 32'(s0_if.ready), 32'(0));
        chk("mid_m_valid", 32'(m_valid), 32'(0));
        chk("mid_orphan", 32'(orphan_err), 32'(0));
        rst = 1'b0;
        #1;
        chk("mid_idle_busy", 32'(busy), 32'(0));
        s0_if.valid = 1'b1;
        #1;
        chk("mid_fresh_grant", 32'(s0_if.ready), 32'(1));
        s0_if.valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
